// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RISC-V opcode constants, the immediate-format tag and the
// immediate decoder used by imm_gen_stage.
//   SIGN_EXTEND(val, w) : sign-extends a w-bit variable to 64 bits.
//   imm_decode(instr, rv64) : returns the 64-bit extended immediate and its tag.
//     Callers with XLEN=32 keep the low 32 bits. Sign extension to 64 bits
//     truncates to the correct 32-bit value.

`ifndef SIGN_EXTEND
`define SIGN_EXTEND(val, w) {{(64 - (w)){val[(w) - 1]}}, val}
`endif

package rv32i_pkg;

   localparam logic [6:0] OPCODE_I_TYPE_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_I_TYPE_ALU   = 7'b0010011;
   localparam logic [6:0] OPCODE_I_TYPE_ALU_W = 7'b0011011;
   localparam logic [6:0] OPCODE_I_TYPE_JALR  = 7'b1100111;
   localparam logic [6:0] OPCODE_S_TYPE       = 7'b0100011;
   localparam logic [6:0] OPCODE_B_TYPE       = 7'b1100011;
   localparam logic [6:0] OPCODE_U_TYPE_LUI   = 7'b0110111;
   localparam logic [6:0] OPCODE_U_TYPE_AUIPC = 7'b0010111;
   localparam logic [6:0] OPCODE_J_TYPE       = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM       = 7'b1110011;

   typedef enum logic [2:0] {
      ImmNone  = 3'd0,
      ImmI     = 3'd1,
      ImmS     = 3'd2,
      ImmB     = 3'd3,
      ImmU     = 3'd4,
      ImmJ     = 3'd5,
      ImmShamt = 3'd6,
      ImmZimm  = 3'd7
   } imm_type_e;

   typedef struct packed {
      logic [63:0] imm;
      imm_type_e   imm_type;
   } imm_dec_t;

   function automatic imm_dec_t imm_decode(input logic [31:0] instr, input logic rv64);
      imm_dec_t    res;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [11:0] imm_i;
      logic [11:0] imm_s;
      logic [12:0] imm_b;
      logic [31:0] imm_u;
      logic [20:0] imm_j;
      logic        is_shift;

      opcode   = instr[6:0];
      funct3   = instr[14:12];
      imm_i    = instr[31:20];
      imm_s    = {instr[31:25], instr[11:7]};
      imm_b    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_u    = {instr[31:12], 12'b0};
      imm_j    = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

      res.imm      = '0;
      res.imm_type = ImmNone;

      case (opcode)
         OPCODE_I_TYPE_LOAD, OPCODE_I_TYPE_JALR: begin
            res.imm      = `SIGN_EXTEND(imm_i, 12);
            res.imm_type = ImmI;
         end
         OPCODE_I_TYPE_ALU: begin
            if (is_shift) begin
               // RV64 shifts use a 6-bit shamt; bit 25 is part of funct7 on RV32.
               res.imm      = rv64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
               res.imm_type = ImmShamt;
            end else begin
               res.imm      = `SIGN_EXTEND(imm_i, 12);
               res.imm_type = ImmI;
            end
         end
         OPCODE_I_TYPE_ALU_W: begin
            // Word ops exist only on RV64; on RV32 this opcode is illegal.
            if (rv64) begin
               if (is_shift) begin
                  res.imm      = {59'b0, instr[24:20]};
                  res.imm_type = ImmShamt;
               end else begin
                  res.imm      = `SIGN_EXTEND(imm_i, 12);
                  res.imm_type = ImmI;
               end
            end
         end
         OPCODE_S_TYPE: begin
            res.imm      = `SIGN_EXTEND(imm_s, 12);
            res.imm_type = ImmS;
         end
         OPCODE_B_TYPE: begin
            res.imm      = `SIGN_EXTEND(imm_b, 13);
            res.imm_type = ImmB;
         end
         OPCODE_U_TYPE_LUI, OPCODE_U_TYPE_AUIPC: begin
            res.imm      = `SIGN_EXTEND(imm_u, 32);
            res.imm_type = ImmU;
         end
         OPCODE_J_TYPE: begin
            res.imm      = `SIGN_EXTEND(imm_j, 21);
            res.imm_type = ImmJ;
         end
         OPCODE_SYSTEM: begin
            // Only the CSR*I forms carry a zimm in rs1.
            if (funct3[2]) begin
               res.imm      = {59'b0, instr[19:15]};
               res.imm_type = ImmZimm;
            end
         end
         default: begin
            res.imm      = '0;
            res.imm_type = ImmNone;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready register slice with full throughput.
//   Main register M drives the outputs. Skid register K catches one entry that
//   arrives while M is stalled. in_ready_o is !K.valid, so it is registered.
//   flush_i drops both entries and wins over any handshake in the same cycle.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   flush_i                  : discard held entries
//   in_valid_i / in_ready_o  : upstream handshake, in_data_i payload
//   out_valid_o / out_ready_i: downstream handshake, out_data_o payload

module skid_buffer #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   logic             m_valid_q, m_valid_d;
   logic             k_valid_q, k_valid_d;
   logic [Width-1:0] m_data_q, m_data_d;
   logic [Width-1:0] k_data_q, k_data_d;
   logic             in_fire;
   logic             drain;

   assign in_ready_o  = ~k_valid_q;
   assign out_valid_o = m_valid_q;
   assign out_data_o  = m_data_q;

   always_comb begin
      m_valid_d = m_valid_q;
      k_valid_d = k_valid_q;
      m_data_d  = m_data_q;
      k_data_d  = k_data_q;
      in_fire   = in_valid_i & ~k_valid_q;
      drain     = m_valid_q & out_ready_i;

      if (flush_i) begin
         m_valid_d = 1'b0;
         k_valid_d = 1'b0;
      end else if (drain) begin
         if (k_valid_q) begin
            // in_ready_o is low here, so no new entry can arrive this cycle.
            m_data_d  = k_data_q;
            k_valid_d = 1'b0;
         end else if (in_fire) begin
            m_data_d = in_data_i;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (!m_valid_q) begin
         if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data_i;
         end
      end else if (in_fire) begin
         k_valid_d = 1'b1;
         k_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_valid_q <= 1'b0;
         k_valid_q <= 1'b0;
         m_data_q  <= '0;
         k_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         k_valid_q <= k_valid_d;
         m_data_q  <= m_data_d;
         k_data_q  <= k_data_d;
      end
   end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage between fetch and decode.
//   The immediate, its format tag and pc + imm are computed from the incoming
//   instruction and then registered with it through a two-entry skid buffer.
//   This gives one cycle of latency and full throughput under backpressure.
// Ports:
//   clk_in, rst_in, flush_in         : clock, sync active-high reset, flush
//   in_valid_in / in_ready_out       : upstream handshake (instr_in, pc_in)
//   out_valid_out / out_ready_in     : downstream handshake
//   imm_out, imm_type_out, target_out: decoded immediate, tag, pc + imm
//   instr_out, pc_out                : pass-through of the accepted entry

module imm_gen_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            flush_in,
   input  logic            in_valid_in,
   output logic            in_ready_out,
   input  logic [ILEN-1:0] instr_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid_out,
   input  logic            out_ready_in,
   output logic [XLEN-1:0] imm_out,
   output logic [2:0]      imm_type_out,
   output logic [XLEN-1:0] target_out,
   output logic [ILEN-1:0] instr_out,
   output logic [XLEN-1:0] pc_out
);

   localparam int unsigned PayloadW = ILEN + 3 * XLEN + 3;
   localparam logic        Rv64     = (XLEN == 64);

   imm_dec_t            dec;
   logic [XLEN-1:0]     imm_in;
   logic [XLEN-1:0]     target_in;
   logic [PayloadW-1:0] in_data;
   logic [PayloadW-1:0] out_data;
   logic                unused_imm;

   assign dec        = imm_decode(instr_in, Rv64);
   assign imm_in     = dec.imm[XLEN-1:0];
   assign unused_imm = ^dec.imm;
   assign target_in  = pc_in + imm_in;
   assign in_data    = {instr_in, pc_in, imm_in, dec.imm_type, target_in};

   skid_buffer #(
      .Width(PayloadW)
   ) u_skid (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .flush_i    (flush_in),
      .in_valid_i (in_valid_in),
      .in_ready_o (in_ready_out),
      .in_data_i  (in_data),
      .out_valid_o(out_valid_out),
      .out_ready_i(out_ready_in),
      .out_data_o (out_data)
   );

   assign {instr_out, pc_out, imm_out, imm_type_out, target_out} = out_data;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked against a queue model plus an arithmetic decoder.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] instr;
   logic [63:0] pc;

   logic        rdy32, v32, rdy64, v64;
   logic [31:0] imm32, tgt32, ins32, pco32, ins64;
   logic [63:0] imm64, tgt64, pco64;
   logic [2:0]  ty32, ty64;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;
   ent_t mq[$];

   logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h13, 7'h1B, 7'h67, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};
   logic [31:0] blist [4] = '{32'h00500093, 32'h00A12023, 32'h004000EF, 32'h123450B7};

   imm_gen_stage #(.XLEN(32)) dut32 (
      .clk_in(clk), .rst_in(rst), .flush_in(flush), .in_valid_in(in_valid),
      .in_ready_out(rdy32), .instr_in(instr), .pc_in(pc[31:0]), .out_valid_out(v32),
      .out_ready_in(out_ready), .imm_out(imm32), .imm_type_out(ty32), .target_out(tgt32),
      .instr_out(ins32), .pc_out(pco32)
   );

   imm_gen_stage #(.XLEN(64)) dut64 (
      .clk_in(clk), .rst_in(rst), .flush_in(flush), .in_valid_in(in_valid),
      .in_ready_out(rdy64), .instr_in(instr), .pc_in(pc), .out_valid_out(v64),
      .out_ready_in(out_ready), .imm_out(imm64), .imm_type_out(ty64), .target_out(tgt64),
      .instr_out(ins64), .pc_out(pco64)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Tags: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit rv64,
                                           output int typ);
      longint      sv;
      logic [63:0] v;
      logic [2:0]  f3;
      bit          shift;
      f3    = ins[14:12];
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      sv    = 0;
      typ   = 0;
      case (ins[6:0])
         7'h03, 7'h67: begin sv = $signed(ins[31:20]); typ = 1; end
         7'h13: begin
            if (shift) begin
               sv  = rv64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
               typ = 6;
            end else begin
               sv = $signed(ins[31:20]); typ = 1;
            end
         end
         7'h1B: begin
            if (rv64 && shift) begin sv = longint'(ins[24:20]); typ = 6; end
            else if (rv64) begin sv = $signed(ins[31:20]); typ = 1; end
         end
         7'h23: begin sv = $signed({ins[31:25], ins[11:7]}); typ = 2; end
         7'h63: begin sv = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); typ = 3; end
         7'h37, 7'h17: begin sv = $signed({ins[31:12], 12'b0}); typ = 4; end
         7'h6F: begin sv = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); typ = 5; end
         7'h73: if (ins[14]) begin sv = longint'(ins[19:15]); typ = 7; end
         default: begin sv = 0; typ = 0; end
      endcase
      v = sv;
      if (!rv64) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   task automatic check_model();
      logic [63:0] e32, e64, t64;
      logic [31:0] t32;
      int          y32, y64;
      chk("ready32", 64'(rdy32), 64'(mq.size() < 2));
      chk("ready64", 64'(rdy64), 64'(mq.size() < 2));
      chk("valid32", 64'(v32), 64'(mq.size() > 0));
      chk("valid64", 64'(v64), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         e32 = ref_imm(mq[0].instr, 1'b0, y32);
         e64 = ref_imm(mq[0].instr, 1'b1, y64);
         t32 = mq[0].pc[31:0] + e32[31:0];
         t64 = mq[0].pc + e64;
         chk("imm32", 64'(imm32), e32);
         chk("type32", 64'(ty32), 64'(y32));
         chk("target32", 64'(tgt32), 64'(t32));
         chk("instr32", 64'(ins32), 64'(mq[0].instr));
         chk("pc32", 64'(pco32), 64'(mq[0].pc[31:0]));
         chk("imm64", imm64, e64);
         chk("type64", 64'(ty64), 64'(y64));
         chk("target64", tgt64, t64);
         chk("instr64", 64'(ins64), 64'(mq[0].instr));
         chk("pc64", pco64, mq[0].pc);
      end
   endtask

   // Check current outputs, advance one clock and step the queue model.
   task automatic cycle(output bit acc);
      bit   ofire;
      ent_t e;
      check_model();
      acc   = in_valid && (mq.size() < 2);
      ofire = (mq.size() > 0) && out_ready;
      e.instr = instr;
      e.pc    = pc;
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
      end else begin
         if (ofire) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [63:0] pcv);
      bit acc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      instr     = ins;
      pc        = pcv;
      cycle(acc);
      in_valid  = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"}, 64'({v32, v64}), 64'd0);
      chk({tag, "_ready"}, 64'({rdy32, rdy64}), 64'd3);
      chk({tag, "_imm"}, 64'(imm32) | imm64, 64'd0);
      chk({tag, "_type"}, 64'({ty32, ty64}), 64'd0);
      chk({tag, "_target"}, 64'(tgt32) | tgt64, 64'd0);
      chk({tag, "_instr"}, 64'(ins32) | 64'(ins64), 64'd0);
      chk({tag, "_pc"}, 64'(pco32) | pco64, 64'd0);
   endtask

   initial begin
      bit acc;
      int idx;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = '0; pc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_reset_state("reset");

      // Directed decode vectors.
      send(32'hFFF00093, 64'h100);
      chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
      chk("addi_type", 64'(ty32), 64'd1);
      chk("addi_target", 64'(tgt32), 64'hFF);
      send(32'h4030D093, 64'h0);
      chk("srai_imm", 64'(imm32), 64'd3);
      chk("srai_type", 64'(ty32), 64'd6);
      send(32'hFE000EE3, 64'h100);
      chk("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
      chk("beq_type", 64'(ty32), 64'd3);
      chk("beq_target", 64'(tgt32), 64'hFC);
      send(32'h0FCF5073, 64'h0);
      chk("csrrwi_imm", 64'(imm32), 64'h1E);
      chk("csrrwi_type", 64'(ty32), 64'd7);
      send(32'h800000B7, 64'h0);
      chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("lui_type64", 64'(ty64), 64'd4);
      send(32'h03F0D093, 64'h0);
      chk("srli_imm64", imm64, 64'd63);
      chk("srli_type64", 64'(ty64), 64'd6);
      chk("srli_imm32", 64'(imm32), 64'd31);
      send(32'h0000007F, 64'h1234);
      chk("unknown_imm", 64'(imm32) | imm64, 64'd0);
      chk("unknown_type", 64'({ty32, ty64}), 64'd0);
      cycle(acc);

      // Backpressure: A and B fill M and K, C stalls, then all drain in order.
      out_ready = 1'b0; in_valid = 1'b1;
      instr = blist[0]; pc = 64'h200; cycle(acc); chk("bp_a_acc", 64'(acc), 64'd1);
      instr = blist[1]; pc = 64'h204; cycle(acc); chk("bp_b_acc", 64'(acc), 64'd1);
      chk("bp_ready_low", 64'({rdy32, rdy64}), 64'd0);
      instr = blist[2]; pc = 64'h208; cycle(acc); chk("bp_c_blocked", 64'(acc), 64'd0);
      out_ready = 1'b1;
      idx = 2;
      for (int k = 0; k < 4; k++) begin
         chk("bp_order_valid", 64'(v32), 64'd1);
         chk("bp_order", 64'(ins32), 64'(blist[k]));
         chk("bp_order64", 64'(ins64), 64'(blist[k]));
         cycle(acc);
         if (acc) begin
            idx++;
            if (idx < 4) begin
               instr = blist[idx];
               pc    = 64'h200 + 64'(4 * idx);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("bp_empty", 64'(v32), 64'd0);

      // Flush with two entries held and a new one offered.
      out_ready = 1'b0; in_valid = 1'b1;
      instr = 32'h00700113; pc = 64'h400; cycle(acc);
      instr = 32'h00812223; pc = 64'h404; cycle(acc);
      instr = 32'h0080006F; pc = 64'h408; flush = 1'b1; cycle(acc);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 64'({v32, v64}), 64'd0);
      chk("flush_ready", 64'({rdy32, rdy64}), 64'd3);
      out_ready = 1'b1;
      repeat (3) begin
         cycle(acc);
         chk("flush_gone", 64'({v32, v64}), 64'd0);
      end

      // Reset with one entry held.
      out_ready = 1'b0; in_valid = 1'b1;
      instr = 32'hFFF00093; pc = 64'h300; cycle(acc);
      instr = 32'h800000B7; pc = 64'h304; rst = 1'b1; cycle(acc);
      rst = 1'b0; in_valid = 1'b0;
      chk_reset_state("midreset");

      // Random traffic with occasional flush and reset.
      acc = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            instr    = $urandom();
            instr[6:0] = ops[$urandom_range(0, 11)];
            pc       = {$urandom(), $urandom()};
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         cycle(acc);
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
